// File: rtl/ts_mod.sv
`default_nettype none
// ============================================================================
// Module   : ts_mod
// Purpose  : Millisecond/second timebase with tick strobes and a one-shot alarm.
// Revision : 1.0  initial release
// ============================================================================
module ts_mod #(
    parameter int CYC_PER_MS = 1000,
    parameter int SEC_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [9:0]       ms_in,
    input  logic [SEC_W-1:0] sec_in,
    input  logic [9:0]       alarm_ms,
    input  logic [SEC_W-1:0] alarm_sec,
    input  logic             alarm_en,
    output logic [9:0]       ms,
    output logic [SEC_W-1:0] sec,
    output logic             ms_tick,
    output logic             sec_tick,
    output logic             alarm
);

    localparam int                  c_PCNT_W   = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(CYC_PER_MS - 1);
    localparam logic [9:0]          c_MS_MAX   = 10'd999;

    logic [c_PCNT_W-1:0] r_pcnt;
    logic [9:0]          r_ms;
    logic [SEC_W-1:0]    r_sec;
    logic                r_ms_tick;
    logic                r_sec_tick;
    logic                r_alarm;
    logic                r_upd;

    logic                w_adv;
    logic [9:0]          w_ms_ld;
    logic                w_match;

    assign w_adv   = en && (r_pcnt == c_PCNT_MAX);
    assign w_ms_ld = (ms_in > c_MS_MAX) ? c_MS_MAX : ms_in;
    assign w_match = (r_ms == alarm_ms) && (r_sec == alarm_sec);

    // r_upd marks that the timestamp was just written by an advance or a load,
    // so the alarm fires once on arrival and not while the value is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt     <= '0;
            r_ms       <= '0;
            r_sec      <= '0;
            r_ms_tick  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_alarm    <= 1'b0;
            r_upd      <= 1'b0;
        end else if (clr) begin
            r_pcnt     <= '0;
            r_ms       <= '0;
            r_sec      <= '0;
            r_ms_tick  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_alarm    <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_alarm    <= r_upd && w_match && alarm_en;
            r_ms_tick  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_upd      <= 1'b0;
            if (load) begin
                r_pcnt <= '0;
                r_ms   <= w_ms_ld;
                r_sec  <= sec_in;
                r_upd  <= 1'b1;
            end else if (w_adv) begin
                r_pcnt    <= '0;
                r_ms_tick <= 1'b1;
                r_upd     <= 1'b1;
                if (r_ms == c_MS_MAX) begin
                    r_ms       <= '0;
                    r_sec      <= r_sec + SEC_W'(1);
                    r_sec_tick <= 1'b1;
                end else begin
                    r_ms <= r_ms + 10'd1;
                end
            end else if (en) begin
                r_pcnt <= r_pcnt + c_PCNT_W'(1);
            end
        end
    end

    assign ms       = r_ms;
    assign sec      = r_sec;
    assign ms_tick  = r_ms_tick;
    assign sec_tick = r_sec_tick;
    assign alarm    = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_ts_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_ts_mod
// Purpose  : Scoreboard bench for ts_mod with CYC_PER_MS=4, SEC_W=32.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ts_mod;

    localparam int C  = 4;
    localparam int SW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0, clr = 1'b0, load = 1'b0, alarm_en = 1'b0;
    logic [9:0]    ms_in = '0, alarm_ms = '0;
    logic [SW-1:0] sec_in = '0, alarm_sec = '0;
    logic [9:0]    ms;
    logic [SW-1:0] sec;
    logic          ms_tick, sec_tick, alarm;

    ts_mod #(.CYC_PER_MS(C), .SEC_W(SW)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .ms_in(ms_in), .sec_in(sec_in), .alarm_ms(alarm_ms), .alarm_sec(alarm_sec),
        .alarm_en(alarm_en), .ms(ms), .sec(sec), .ms_tick(ms_tick),
        .sec_tick(sec_tick), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]    ms;
        logic [SW-1:0] sec;
        logic          mt, st, al;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   m_pcnt;
    bit   m_pend;
    int   vectors = 0, errors = 0;
    int   n_mt, n_st, n_al;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pcnt = 0;
        m_pend = 1'b0;
        m = '{ms: '0, sec: '0, mt: 1'b0, st: 1'b0, al: 1'b0};
    endtask

    // Reference model advanced on each clock, expected outputs queued for the edge.
    task automatic step();
        exp_t e;
        if (clr) begin
            model_reset();
        end else begin
            m.al   = m_pend && alarm_en && (m.ms == alarm_ms) && (m.sec == alarm_sec);
            m.mt   = 1'b0;
            m.st   = 1'b0;
            m_pend = 1'b0;
            if (load) begin
                m.ms   = (ms_in > 10'd999) ? 10'd999 : ms_in;
                m.sec  = sec_in;
                m_pcnt = 0;
                m_pend = 1'b1;
            end else if (en) begin
                m_pcnt++;
                if (m_pcnt == C) begin
                    m_pcnt = 0;
                    m.mt   = 1'b1;
                    m_pend = 1'b1;
                    if (m.ms == 10'd999) begin
                        m.ms  = '0;
                        m.sec = m.sec + 1;
                        m.st  = 1'b1;
                    end else begin
                        m.ms = m.ms + 10'd1;
                    end
                end
            end
        end
        q.push_back(m);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("ms", 64'(ms), 64'(e.ms));
        chk("sec", 64'(sec), 64'(e.sec));
        chk("ms_tick", 64'(ms_tick), 64'(e.mt));
        chk("sec_tick", 64'(sec_tick), 64'(e.st));
        chk("alarm", 64'(alarm), 64'(e.al));
        n_mt += int'(ms_tick);
        n_st += int'(sec_tick);
        n_al += int'(alarm);
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b1;
        #1;
        chk("rst_ms", 64'(ms), 64'd0);
        chk("rst_sec", 64'(sec), 64'd0);
        chk("rst_ticks", 64'({ms_tick, sec_tick, alarm}), 64'd0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int first_mt, first_st, first_al, idx;
        model_reset();
        #12;
        chk("reset_ms", 64'(ms), 64'd0);
        chk("reset_sec", 64'(sec), 64'd0);
        chk("reset_ticks", 64'({ms_tick, sec_tick, alarm}), 64'd0);
        rst = 1'b0;

        // Free run to the first second rollover
        en = 1'b1;
        n_mt = 0; n_st = 0; first_mt = -1; first_st = -1;
        for (int i = 1; i <= 1000 * C; i++) begin
            step();
            if (ms_tick && first_mt < 0) first_mt = i;
            if (sec_tick && first_st < 0) first_st = i;
        end
        chk("first_ms_tick", 64'(first_mt), 64'(C));
        chk("first_sec_tick", 64'(first_st), 64'(1000 * C));
        chk("ms_tick_count", 64'(n_mt), 64'd1000);
        chk("sec_tick_count", 64'(n_st), 64'd1);
        chk("run_ms", 64'(ms), 64'd0);
        chk("run_sec", 64'(sec), 64'd1);

        // Load near a rollover, including a clamped load
        load = 1'b1; ms_in = 10'd998; sec_in = 32'd5;
        step();
        load = 1'b0;
        chk("load_ms", 64'(ms), 64'd998);
        chk("load_tick", 64'(ms_tick), 64'd0);
        repeat (C) step();
        chk("load_ms999", 64'(ms), 64'd999);
        repeat (C) step();
        chk("load_wrap_ms", 64'(ms), 64'd0);
        chk("load_wrap_sec", 64'(sec), 64'd6);
        chk("load_wrap_tick", 64'(sec_tick), 64'd1);
        load = 1'b1; ms_in = 10'd1023;
        step();
        load = 1'b0;
        chk("clamp_ms", 64'(ms), 64'd999);

        // Alarm at 0.003 s counted from reset
        async_reset_check();
        alarm_en = 1'b1; alarm_sec = '0; alarm_ms = 10'd3;
        n_al = 0; first_al = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (alarm && first_al < 0) first_al = i;
        end
        chk("alarm_count", 64'(n_al), 64'd1);
        chk("alarm_cycle", 64'(first_al), 64'(3 * C + 1));
        alarm_en = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; n_al = 0;
        repeat (30) step();
        chk("alarm_off_count", 64'(n_al), 64'd0);

        // Enable gap mid-prescale delays the tick by the gap length
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (2) step();
        en = 1'b0; n_mt = 0;
        repeat (10) step();
        chk("hold_ms", 64'(ms), 64'd0);
        chk("hold_ticks", 64'(n_mt), 64'd0);
        en = 1'b1; idx = 12;
        while (!ms_tick && idx < 40) begin
            step();
            idx++;
        end
        chk("gap_tick_cycle", 64'(idx), 64'(C + 10));

        // clr and load together while counting
        repeat (7) step();
        alarm_en = 1'b1; alarm_ms = '0; alarm_sec = '0;
        clr = 1'b1; load = 1'b1; ms_in = 10'd500; sec_in = 32'd7;
        step();
        clr = 1'b0; load = 1'b0;
        chk("clrld_ms", 64'(ms), 64'd0);
        chk("clrld_sec", 64'(sec), 64'd0);
        chk("clrld_ticks", 64'({ms_tick, sec_tick}), 64'd0);
        step();
        chk("clrld_alarm", 64'(alarm), 64'd0);
        alarm_en = 1'b0;

        // Seconds counter wrap
        load = 1'b1; ms_in = 10'd999; sec_in = '1;
        step();
        load = 1'b0;
        repeat (C) step();
        chk("wrap_sec", 64'(sec), 64'd0);
        chk("wrap_ms", 64'(ms), 64'd0);
        chk("wrap_tick", 64'(sec_tick), 64'd1);

        // Asynchronous reset mid-count, no tick on release
        repeat (5) step();
        async_reset_check();
        step();
        chk("post_rst_tick", 64'(ms_tick), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
